// File: rtl/hdp_pkg.sv
// Shared types and constants for the HDP-1280-2 register sequencer.
package hdp_pkg;

  typedef enum logic [2:0] {
    ST_INIT_GAP,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_READY,
    ST_HOST_ISSUE,
    ST_HOST_WAIT,
    ST_GAP
  } state_t;

  localparam logic HDP_RD_BIT = 1'b1;
  localparam logic HDP_WR_BIT = 1'b0;

  localparam int unsigned INIT_ENTRY_W = 15;

endpackage

// File: rtl/hdp_reg_sequencer_if.sv
// Host request/response port plus SPI engine command port of the sequencer.
interface hdp_reg_sequencer_if;

  logic       enable;
  logic       req_valid;
  logic       req_ready;
  logic       req_rnw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       init_done;
  logic       init_error;
  logic       spi_enable;
  logic       spi_start;
  logic [7:0] spi_tx_upper;
  logic [7:0] spi_tx_lower;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_rx_lower;

  modport slave (
    input  enable, req_valid, req_rnw, req_addr, req_wdata,
           spi_busy, spi_done, spi_rx_lower,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, init_done, init_error,
           spi_enable, spi_start, spi_tx_upper, spi_tx_lower
  );

  modport master (
    output enable, req_valid, req_rnw, req_addr, req_wdata,
           spi_busy, spi_done, spi_rx_lower,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, init_done, init_error,
           spi_enable, spi_start, spi_tx_upper, spi_tx_lower
  );

endinterface

// File: rtl/hdp_init_rom.sv
// HDP-1280-2 power-up register table: index -> {addr[6:0], data[7:0]}.
module hdp_init_rom
  import hdp_pkg::*;
#(
  parameter int unsigned INIT_LEN = 8
) (
  input  logic [3:0]              index,
  output logic [INIT_ENTRY_W-1:0] entry
);

  logic [INIT_ENTRY_W-1:0] raw;

  always_comb begin
    raw = '0;
    unique case (index)
      4'd0:  raw = {7'h00, 8'h01};
      4'd1:  raw = {7'h01, 8'h0F};
      4'd2:  raw = {7'h02, 8'h40};
      4'd3:  raw = {7'h03, 8'h80};
      4'd4:  raw = {7'h06, 8'h22};
      4'd5:  raw = {7'h07, 8'h3C};
      4'd6:  raw = {7'h0A, 8'h11};
      4'd7:  raw = {7'h0B, 8'h05};
      4'd8:  raw = {7'h0C, 8'h00};
      4'd9:  raw = {7'h0D, 8'h7F};
      4'd10: raw = {7'h10, 8'hA0};
      4'd11: raw = {7'h11, 8'h0A};
      4'd12: raw = {7'h14, 8'h33};
      4'd13: raw = {7'h15, 8'h18};
      4'd14: raw = {7'h20, 8'h01};
      4'd15: raw = {7'h21, 8'h00};
      default: raw = '0;
    endcase
  end

  assign entry = (32'(index) >= INIT_LEN) ? '0 : raw;

endmodule

// File: rtl/hdp_reg_sequencer.sv
// Replays the init table into the SLM driver after reset, then serves single
// host register reads/writes through the HDP-1280-2 SPI engine.
module hdp_reg_sequencer
  import hdp_pkg::*;
#(
  parameter int unsigned INIT_LEN       = 8,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned CNT_W          = 12
) (
  input  logic i_clock,
  input  logic i_reset,
  hdp_reg_sequencer_if.slave bus
);

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [4:0]              idx;
  logic                    pend, start;
  logic [7:0]              tx_upper, tx_lower;
  logic                    lat_rnw;
  logic [6:0]              lat_addr;
  logic [7:0]              lat_wdata;
  logic                    rsp_valid, rsp_error;
  logic [7:0]              rsp_rdata;
  logic                    init_done, init_error;
  logic [INIT_ENTRY_W-1:0] rom_entry;
  logic [7:0]              issue_upper, issue_lower;
  logic                    launch, accept, xfer_ok, xfer_tmo, cnt_clr;
  logic                    gap_end, tmo_hit, can_launch, last_entry;

  hdp_init_rom #(.INIT_LEN(INIT_LEN)) u_rom (
    .index (idx[3:0]),
    .entry (rom_entry)
  );

  assign gap_end    = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign tmo_hit    = (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign can_launch = bus.enable && !bus.spi_busy;
  assign last_entry = (idx == 5'(INIT_LEN - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= ST_INIT_GAP;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    accept     = 1'b0;
    xfer_ok    = 1'b0;
    xfer_tmo   = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state)
      ST_INIT_GAP: if (gap_end) begin
        state_next = ST_INIT_ISSUE;
        cnt_clr    = 1'b1;
      end
      ST_INIT_ISSUE: if (can_launch) begin
        launch     = 1'b1;
        state_next = ST_INIT_WAIT;
      end
      ST_INIT_WAIT, ST_HOST_WAIT: begin
        // done wins over a timeout landing on the same cycle
        if (bus.spi_done) begin
          xfer_ok    = 1'b1;
          cnt_clr    = 1'b1;
          state_next = (state == ST_INIT_WAIT && !last_entry) ? ST_INIT_GAP : ST_GAP;
        end else if (tmo_hit) begin
          xfer_tmo   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_READY: if (bus.req_valid && bus.enable) begin
        accept     = 1'b1;
        state_next = ST_HOST_ISSUE;
      end
      ST_HOST_ISSUE: if (can_launch) begin
        launch     = 1'b1;
        state_next = ST_HOST_WAIT;
      end
      ST_GAP: if (gap_end) begin
        state_next = ST_READY;
        cnt_clr    = 1'b1;
      end
      default: state_next = ST_INIT_GAP;
    endcase
  end

  always_comb begin
    issue_upper = '0;
    issue_lower = '0;
    if (state == ST_INIT_ISSUE) begin
      issue_upper = {HDP_WR_BIT, rom_entry[14:8]};
      issue_lower = rom_entry[7:0];
    end else begin
      issue_upper = {lat_rnw, lat_addr};
      issue_lower = (lat_rnw == HDP_RD_BIT) ? 8'h00 : lat_wdata;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt        <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      start      <= 1'b0;
      tx_upper   <= '0;
      tx_lower   <= '0;
      lat_rnw    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_rdata  <= '0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
    end else begin
      // bytes load on launch, strobe follows one cycle later; the timeout
      // count is held at zero until the strobe cycle itself
      pend  <= launch;
      start <= pend;
      if (cnt_clr || launch || pend)
        cnt <= '0;
      else if (state inside {ST_INIT_GAP, ST_GAP, ST_INIT_WAIT, ST_HOST_WAIT})
        cnt <= cnt + 1'b1;
      if (launch) begin
        tx_upper <= issue_upper;
        tx_lower <= issue_lower;
      end
      if (accept) begin
        lat_rnw   <= bus.req_rnw;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      rsp_valid <= 1'b0;
      if (state == ST_HOST_WAIT && (xfer_ok || xfer_tmo)) begin
        rsp_valid <= 1'b1;
        rsp_error <= xfer_tmo;
        rsp_rdata <= (xfer_ok && lat_rnw == HDP_RD_BIT) ? bus.spi_rx_lower : '0;
      end
      if (state == ST_INIT_WAIT) begin
        if (xfer_ok) begin
          idx <= idx + 1'b1;
          if (last_entry) init_done <= 1'b1;
        end
        if (xfer_tmo) init_error <= 1'b1;
      end
    end
  end

  assign bus.req_ready    = (state == ST_READY);
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_rdata    = rsp_rdata;
  assign bus.rsp_error    = rsp_error;
  assign bus.init_done    = init_done;
  assign bus.init_error   = init_error;
  assign bus.spi_enable   = 1'b1;
  assign bus.spi_start    = start;
  assign bus.spi_tx_upper = tx_upper;
  assign bus.spi_tx_lower = tx_lower;

endmodule

// File: tb/tb_hdp_reg_sequencer.sv
// Directed bench for hdp_reg_sequencer with a behavioural SPI engine model.
module tb_hdp_reg_sequencer;

  localparam int unsigned GAP   = 64;
  localparam int unsigned TMO   = 4095;
  localparam int unsigned NINIT = 8;
  localparam int unsigned NV    = 8;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clock = ~i_clock;

  hdp_reg_sequencer_if bus ();

  hdp_reg_sequencer #(
    .INIT_LEN       (NINIT),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (12)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // SPI engine model: done after done_delay cycles, or never for strobe drop_idx
  int unsigned done_delay = 1400;
  int          drop_idx   = -1;
  logic [7:0]  model_rx   = 8'h00;
  logic        force_busy = 1'b0;
  logic        force_done = 1'b0;
  logic        m_done, m_busy, m_armed;
  int unsigned m_cnt;
  int          m_strobes;

  assign bus.spi_busy     = m_busy | force_busy;
  assign bus.spi_done     = m_done | force_done;
  assign bus.spi_rx_lower = model_rx;

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_armed <= 1'b0; m_cnt <= 0; m_strobes <= 0;
    end else begin
      m_done <= 1'b0;
      if (bus.spi_start) begin
        m_strobes <= m_strobes + 1;
        m_armed   <= (m_strobes != drop_idx);
        m_busy    <= (m_strobes != drop_idx);
        m_cnt     <= 1;
      end else if (m_armed) begin
        if (m_cnt == done_delay) begin
          m_done <= 1'b1; m_armed <= 1'b0; m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // Monitor on the falling edge: per-strobe bytes, idle time, stability
  int unsigned cyc = 0, idle = 0, strobes = 0, rsp_cnt = 0;
  int unsigned double_cnt = 0, hold_err = 0, err_cyc = 0;
  logic [7:0]  rec_up [64];
  logic [7:0]  rec_lo [64];
  int unsigned rec_idle [64];
  int unsigned rec_cyc [64];
  logic        rec_stable [64];
  logic [7:0]  prev_up = '0, prev_lo = '0;
  logic        prev_start = 1'b0, prev_err = 1'b0;

  always @(negedge i_clock) begin
    cyc        <= cyc + 1;
    prev_up    <= bus.spi_tx_upper;
    prev_lo    <= bus.spi_tx_lower;
    prev_start <= bus.spi_start;
    prev_err   <= bus.init_error;
    if (bus.init_error && !prev_err) err_cyc <= cyc;
    if (i_reset) begin
      idle    <= 0;
      strobes <= 0;
    end else begin
      idle <= bus.spi_done ? 0 : idle + 1;
      if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (bus.spi_start && prev_start) double_cnt <= double_cnt + 1;
      if (bus.spi_start && strobes < 64) begin
        rec_up[strobes]     <= bus.spi_tx_upper;
        rec_lo[strobes]     <= bus.spi_tx_lower;
        rec_idle[strobes]   <= idle;
        rec_cyc[strobes]    <= cyc;
        rec_stable[strobes] <= (prev_up == bus.spi_tx_upper) && (prev_lo == bus.spi_tx_lower);
        strobes             <= strobes + 1;
      end
      if (bus.spi_done && strobes > 0 && strobes <= 64 &&
          (bus.spi_tx_upper != rec_up[strobes-1] || bus.spi_tx_lower != rec_lo[strobes-1]))
        hold_err <= hold_err + 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready),    32'h0);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid),    32'h0);
    check({tag, "_rsp_rdata"},  32'(bus.rsp_rdata),    32'h0);
    check({tag, "_rsp_error"},  32'(bus.rsp_error),    32'h0);
    check({tag, "_init_done"},  32'(bus.init_done),    32'h0);
    check({tag, "_init_error"}, 32'(bus.init_error),   32'h0);
    check({tag, "_spi_enable"}, 32'(bus.spi_enable),   32'h1);
    check({tag, "_spi_start"},  32'(bus.spi_start),    32'h0);
    check({tag, "_tx_upper"},   32'(bus.spi_tx_upper), 32'h0);
    check({tag, "_tx_lower"},   32'(bus.spi_tx_lower), 32'h0);
  endtask

  task automatic wait_ready(input string name, input int unsigned limit);
    int unsigned k = 0;
    while (!bus.req_ready && k < limit) begin
      @(negedge i_clock);
      k++;
    end
    check({name, "_ready_reached"}, 32'(bus.req_ready), 32'h1);
  endtask

  task automatic send_req(input logic rnw, input logic [6:0] addr, input logic [7:0] wdata);
    bus.req_rnw   = rnw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(negedge i_clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output logic [7:0] rdata, output logic err);
    int unsigned k = 0;
    while (!bus.rsp_valid && k < 10000) begin
      @(negedge i_clock);
      k++;
    end
    got   = bus.rsp_valid;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_error;
  endtask

  typedef struct {
    logic        rnw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rx;
    int unsigned delay;
    bit          drop;
    logic [7:0]  exp_up;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [NV];
  logic [14:0] init_tab [NINIT];

  initial begin
    logic        got, err;
    logic [7:0]  rdata;
    int unsigned s0, r0, k;

    init_tab = '{{7'h00, 8'h01}, {7'h01, 8'h0F}, {7'h02, 8'h40}, {7'h03, 8'h80},
                 {7'h06, 8'h22}, {7'h07, 8'h3C}, {7'h0A, 8'h11}, {7'h0B, 8'h05}};
    vecs[0] = '{1'b0, 7'h12, 8'hA5, 8'h77, 30,   1'b0, 8'h12, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 7'h05, 8'h99, 8'h3C, 30,   1'b0, 8'h85, 8'h00, 8'h3C, 1'b0};
    vecs[2] = '{1'b1, 7'h33, 8'h00, 8'h5A, 30,   1'b1, 8'hB3, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 7'h33, 8'h0F, 8'h11, 10,   1'b0, 8'h33, 8'h0F, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 7'h7F, 8'h00, 8'hC3, 4094, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0};
    vecs[5] = '{1'b1, 7'h01, 8'h00, 8'hE1, 4095, 1'b0, 8'h81, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 1,    1'b0, 8'h7F, 8'hFF, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 7'h00, 8'h55, 8'hFF, 1,    1'b0, 8'h80, 8'h00, 8'hFF, 1'b0};

    bus.enable    = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_rnw   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state, then full init replay with a slow engine
    repeat (3) @(negedge i_clock);
    check_reset_vals("rst");
    i_reset = 1'b0;
    wait_ready("init", 20000);
    check("init_done",    32'(bus.init_done),  32'h1);
    check("init_error",   32'(bus.init_error), 32'h0);
    check("init_strobes", strobes,             NINIT);
    check("init_no_rsp",  rsp_cnt,             0);
    for (int i = 0; i < int'(NINIT); i++) begin
      check($sformatf("init%0d_upper", i),  32'(rec_up[i]), 32'({1'b0, init_tab[i][14:8]}));
      check($sformatf("init%0d_lower", i),  32'(rec_lo[i]), 32'(init_tab[i][7:0]));
      check($sformatf("init%0d_stable", i), 32'(rec_stable[i]), 32'h1);
      if (i == 0) check("init0_gap_min", 32'(rec_idle[0] >= GAP), 32'h1);
      else        check($sformatf("init%0d_gap", i), rec_idle[i], GAP + 2);
    end

    // Enable low: a valid request must not be accepted
    s0 = strobes;
    bus.enable = 1'b0;
    bus.req_valid = 1'b1;
    repeat (10) @(negedge i_clock);
    check("en_low_ready",   32'(bus.req_ready), 32'h1);
    check("en_low_strobes", strobes, s0);
    bus.req_valid = 1'b0;
    bus.enable = 1'b1;

    // Busy engine holds the launch
    done_delay = 5;
    force_busy = 1'b1;
    send_req(1'b0, 7'h40, 8'h3E);
    repeat (20) @(negedge i_clock);
    check("busy_no_strobe", strobes, s0);
    check("busy_not_ready", 32'(bus.req_ready), 32'h0);
    force_busy = 1'b0;
    wait_rsp(got, rdata, err);
    check("busy_rsp",     32'(got), 32'h1);
    check("busy_err",     32'(err), 32'h0);
    check("busy_strobes", strobes, s0 + 1);
    check("busy_upper",   32'(rec_up[s0]), 32'h40);
    check("busy_lower",   32'(rec_lo[s0]), 32'h3E);

    // Table-driven host transactions
    for (int i = 0; i < int'(NV); i++) begin
      done_delay = vecs[i].delay;
      model_rx   = vecs[i].rx;
      wait_ready($sformatf("v%0d", i), 10000);
      drop_idx   = vecs[i].drop ? m_strobes : -1;
      s0 = strobes;
      r0 = rsp_cnt;
      send_req(vecs[i].rnw, vecs[i].addr, vecs[i].wdata);
      wait_rsp(got, rdata, err);
      check($sformatf("v%0d_rsp_valid", i), 32'(got),   32'h1);
      check($sformatf("v%0d_rdata", i),     32'(rdata), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_error", i),     32'(err),   32'(vecs[i].exp_err));
      @(negedge i_clock);
      check($sformatf("v%0d_rsp_pulse", i), 32'(bus.rsp_valid), 32'h0);
      check($sformatf("v%0d_rsp_count", i), rsp_cnt, r0 + 1);
      check($sformatf("v%0d_strobes", i),   strobes, s0 + 1);
      check($sformatf("v%0d_upper", i),     32'(rec_up[s0]), 32'(vecs[i].exp_up));
      check($sformatf("v%0d_lower", i),     32'(rec_lo[s0]), 32'(vecs[i].exp_lo));
    end
    drop_idx = -1;

    // Reset while waiting on a host read; a later stray done is ignored
    done_delay = 200;
    wait_ready("rstmid", 10000);
    s0 = strobes;
    send_req(1'b1, 7'h2A, 8'h00);
    k = 0;
    while (strobes == s0 && k < 100) begin
      @(negedge i_clock);
      k++;
    end
    check("rstmid_strobe", strobes, s0 + 1);
    repeat (20) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    check_reset_vals("rstmid");
    i_reset = 1'b0;
    r0 = rsp_cnt;
    done_delay = 20;
    repeat (3) @(negedge i_clock);
    force_done = 1'b1;
    @(negedge i_clock);
    force_done = 1'b0;
    wait_ready("replay", 10000);
    check("replay_no_rsp",  rsp_cnt, r0);
    check("replay_strobes", strobes, NINIT);
    check("replay_upper0",  32'(rec_up[0]), 32'({1'b0, init_tab[0][14:8]}));
    check("replay_lower0",  32'(rec_lo[0]), 32'(init_tab[0][7:0]));
    check("replay_done",    32'(bus.init_done), 32'h1);

    // Init entry 2 never completes
    i_reset  = 1'b1;
    drop_idx = 2;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    wait_ready("inittmo", 10000);
    check("inittmo_error",   32'(bus.init_error), 32'h1);
    check("inittmo_done",    32'(bus.init_done),  32'h0);
    check("inittmo_strobes", strobes, 3);
    check("inittmo_upper2",  32'(rec_up[2]), 32'({1'b0, init_tab[2][14:8]}));
    check("inittmo_latency", err_cyc - rec_cyc[2], TMO + 1);
    repeat (200) @(negedge i_clock);
    check("inittmo_no_more", strobes, 3);
    drop_idx = -1;
    done_delay = 15;
    send_req(1'b0, 7'h09, 8'h5C);
    wait_rsp(got, rdata, err);
    check("after_tmo_rsp",   32'(got), 32'h1);
    check("after_tmo_err",   32'(err), 32'h0);
    check("after_tmo_upper", 32'(rec_up[3]), 32'h09);

    check("start_single_cycle", double_cnt, 0);
    check("tx_held_to_done",    hold_err,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
